// File: rtl/imem_access_stage.sv
// -----------------------------------------------------------------------------
// imem_access_stage
//
// Memory-access pipeline stage placed directly after execute. It accepts one
// execute bundle per transaction and does three things with it:
//   * resolves the branch decision and emits a one-cycle pc_src pulse together
//     with the registered branch target,
//   * for loads and stores at an aligned address, runs a req/ack handshake on
//     the data-memory port and waits in BUSY (stalling upstream) until the ack
//     arrives or the timeout expires,
//   * produces a registered, one-cycle write-back bundle for the register file.
// A misaligned memory access or a memory timeout sets the sticky bus_error flag
// and produces a write-back pulse whose register write is suppressed.
//
// Parameters:
//   WORD     datapath width
//   TIMEOUT  maximum BUSY cycles without mem_ack before the access is aborted
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   valid_in                    execute bundle valid
//   alu_result, store_data      address / ALU result and store data
//   branch_target, zero         branch target and execute zero flag
//   mem_read, mem_write         load / store request (both high = store)
//   branch, uncond_branch       CBZ / B
//   mem_to_reg, reg_write       write-back control
//   write_reg                   destination register index
//   stall                       high while BUSY; upstream holds its bundle
//   pc_src, pc_target           one-cycle take-branch pulse and its target
//   mem_req, mem_we             data-memory request and write enable
//   mem_addr, mem_wdata         request address and write data
//   mem_ack, mem_rdata          memory completion and load data
//   wb_valid                    one-cycle write-back pulse
//   wb_data, wb_reg_write       write-back data and qualified register write
//   wb_reg                      write-back destination index
//   bus_error                   sticky error flag, cleared only by reset
// -----------------------------------------------------------------------------
module imem_access_stage #(
  parameter int WORD    = 64,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [WORD-1:0] alu_result,
  input  logic [WORD-1:0] store_data,
  input  logic [WORD-1:0] branch_target,
  input  logic            zero,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            branch,
  input  logic            uncond_branch,
  input  logic            mem_to_reg,
  input  logic            reg_write,
  input  logic [4:0]      write_reg,
  output logic            stall,
  output logic            pc_src,
  output logic [WORD-1:0] pc_target,
  output logic            mem_req,
  output logic            mem_we,
  output logic [WORD-1:0] mem_addr,
  output logic [WORD-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [WORD-1:0] mem_rdata,
  output logic            wb_valid,
  output logic [WORD-1:0] wb_data,
  output logic            wb_reg_write,
  output logic [4:0]      wb_reg,
  output logic            bus_error
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Counter only has to reach TIMEOUT-1; keep at least one bit for TIMEOUT=1.
  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;

  // Decoded per-cycle events.
  logic            accept;        // bundle taken this edge
  logic            is_mem;        // load or store
  logic            aligned;       // 8-byte aligned address
  logic            ack_done;      // BUSY and memory acknowledged
  logic            timeout_done;  // BUSY, no ack, last allowed cycle

  // Fields of the accepted bundle needed when the memory access completes.
  logic [WORD-1:0] cap_alu;
  logic            cap_mem_to_reg;
  logic            cap_reg_write;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: state-holding processes use non-blocking assignments so every
  // register samples the pre-edge values, independent of process order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && is_mem && aligned) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (ack_done || timeout_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / decode logic
  // ---------------------------------------------------------------------------
  always_comb begin
    stall        = (state == BUSY);
    accept       = (state == IDLE) && valid_in;
    is_mem       = mem_read | mem_write;
    aligned      = (alu_result[2:0] == 3'b000);
    ack_done     = (state == BUSY) && mem_ack;
    // An ack in the last allowed cycle is a normal completion, so the timeout
    // only fires when mem_ack is low.
    timeout_done = (state == BUSY) && !mem_ack && (cnt == CNT_LAST);
  end

  // ---------------------------------------------------------------------------
  // Timeout counter: cleared on accept, counts BUSY cycles without an ack.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if ((state == BUSY) && !mem_ack && !timeout_done) begin
      cnt <= cnt + CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Captured bundle fields used at memory completion
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_alu        <= '0;
      cap_mem_to_reg <= 1'b0;
      cap_reg_write  <= 1'b0;
    end else if (accept) begin
      cap_alu        <= alu_result;
      cap_mem_to_reg <= mem_to_reg;
      cap_reg_write  <= reg_write;
    end
  end

  // ---------------------------------------------------------------------------
  // Branch resolution: registered one-cycle pulse on the accept edge,
  // independent of any memory outcome.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_src    <= 1'b0;
      pc_target <= '0;
    end else begin
      pc_src <= 1'b0;
      if (accept) begin
        pc_src    <= uncond_branch | (branch & zero);
        pc_target <= branch_target;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Data-memory request port. Address and data stay stable while mem_req is
  // high because they are only loaded on accept, which cannot happen in BUSY.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (accept && is_mem && aligned) begin
      mem_req   <= 1'b1;
      mem_we    <= mem_write;
      mem_addr  <= alu_result;
      mem_wdata <= store_data;
    end else if (ack_done || timeout_done) begin
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Write-back bundle and sticky error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_reg_write <= 1'b0;
      wb_reg       <= '0;
      bus_error    <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (accept) begin
        wb_reg <= write_reg;
        if (!is_mem) begin
          wb_valid     <= 1'b1;
          wb_data      <= alu_result;
          wb_reg_write <= reg_write;
        end else if (!aligned) begin
          // Misaligned access: no request, retire immediately without a write.
          wb_valid     <= 1'b1;
          wb_data      <= alu_result;
          wb_reg_write <= 1'b0;
          bus_error    <= 1'b1;
        end
      end else if (ack_done) begin
        wb_valid     <= 1'b1;
        wb_data      <= cap_mem_to_reg ? mem_rdata : cap_alu;
        wb_reg_write <= cap_reg_write;
      end else if (timeout_done) begin
        wb_valid     <= 1'b1;
        wb_data      <= cap_alu;
        wb_reg_write <= 1'b0;
        bus_error    <= 1'b1;
      end
    end
  end

endmodule

// File: doc/imem_access_stage.md
# imem_access_stage

Memory-access stage sitting directly downstream of the execute stage. It registers the execute outputs (ALU result, store data, branch target, zero flag) plus control. It resolves the branch decision and runs a req/ack transaction on the data-memory port for loads and stores. Its output is a registered write-back bundle for the register file.

## Interface
Parameters:
- WORD, 64, datapath width; equals the codebase `WORD` define.
- TIMEOUT, 16, maximum BUSY cycles waiting for mem_ack before aborting; must be ≥ 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- valid_in  input  1  execute bundle valid this cycle.
- alu_result  input  WORD  execute ALU result; memory address for loads and stores.
- store_data  input  WORD  execute read_data2; store write data.
- branch_target  input  WORD  execute branch target.
- zero  input  1  execute zero flag.
- mem_read, mem_write  input  1 each  load or store request; both high is treated as a store.
- branch, uncond_branch  input  1 each  conditional (CBZ) or unconditional (B) branch.
- mem_to_reg, reg_write  input  1 each  write-back control.
- write_reg  input  5  destination register index.
- stall  output  1  high while the stage is BUSY; upstream holds its bundle.
- pc_src  output  1  one-cycle pulse: take the branch.
- pc_target  output  WORD  registered branch target; valid when pc_src is high.
- mem_req  output  1  data-memory request; held until acknowledged.
- mem_we  output  1  request is a write.
- mem_addr, mem_wdata  output  WORD  request address and write data; stable while mem_req is high.
- mem_ack  input  1  memory completion; sampled only while mem_req is high.
- mem_rdata  input  WORD  load data; valid with mem_ack.
- wb_valid  output  1  one-cycle pulse: write-back bundle valid.
- wb_data  output  WORD  load data when mem_to_reg is set, else the ALU result.
- wb_reg_write  output  1  reg_write qualified by success.
- wb_reg  output  5  destination index.
- bus_error  output  1  sticky error flag; cleared only by reset.

## Operation
- States: IDLE, BUSY.
- IDLE, valid_in low: no action.
- IDLE, valid_in high:
  - Capture the whole bundle.
  - pc_src ← uncond_branch | (branch & zero), and pc_target ← branch_target. Both are registered, one-cycle pulse.
- Non-memory op (mem_read = mem_write = 0):
  - Next cycle: wb_valid = 1, wb_data = alu_result, wb_reg_write = reg_write.
  - State stays IDLE.
- Memory op, address aligned (alu_result[2:0] == 0):
  - Register mem_req = 1, mem_we = mem_write, mem_addr = alu_result, mem_wdata = store_data.
  - Enter BUSY and clear the timeout counter.
- Memory op, address misaligned:
  - No request is issued.
  - bus_error ← 1.
  - Next cycle: wb_valid = 1 with wb_reg_write = 0.
  - State stays IDLE.
- BUSY:
  - stall = 1 and valid_in is ignored.
  - The counter increments each cycle that mem_ack is low.
- BUSY, mem_ack high:
  - mem_req drops and state returns to IDLE.
  - wb_valid = 1 and wb_reg_write = captured reg_write.
  - wb_data = mem_rdata if mem_to_reg, else the captured alu_result.
- BUSY, counter reaches TIMEOUT - 1 with mem_ack low:
  - mem_req drops and bus_error ← 1.
  - wb_valid = 1 with wb_reg_write = 0.
  - State returns to IDLE.
- Ack on the timeout cycle: the ack wins and the transaction is a normal completion.
- Branch and memory in the same bundle: pc_src is still produced on the accept edge, independent of the memory outcome.

## Timing
- Reset values: state IDLE and counter 0. Every output is 0: stall, pc_src, pc_target, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_data, wb_reg_write, wb_reg, bus_error.
- Reset is asynchronous and acts mid-transaction: mem_req falls immediately and no wb_valid is produced for the aborted op.
- stall is combinational from state (state == BUSY). It rises the cycle after the accept edge.
  - Upstream advances on the accept edge itself.
  - Upstream holds the following bundle until stall falls.
- Non-memory latency: wb_valid is high in the cycle after the accept edge.
- Memory latency, with the accept at edge E0:
  - mem_req is high from E0.
  - If mem_ack is high in cycle k, it is sampled at edge Ek. mem_req is low and wb_valid is high after Ek.
  - Minimum latency is 2 cycles (ack in the first request cycle).
- Back-to-back: a bundle presented in the cycle stall falls is accepted at that edge.
- pc_src and wb_valid are single-cycle pulses and never held.

## Test plan
- Reset mid-BUSY (mem_req = 1) → mem_req, stall and bus_error are 0 asynchronously; no wb_valid after reset release.
- ADD result 0x1234 with reg_write = 1 and write_reg = 3 → one cycle later wb_valid = 1, wb_data = 0x1234, wb_reg = 3; stall never rises.
- Load at addr 0x40, mem_to_reg = 1, ack after 3 BUSY cycles with rdata 0xDEAD → mem_req high for exactly 3 cycles, stall high for 3 cycles, then wb_data = 0xDEAD.
- Store at addr 0x13 (misaligned) → no mem_req; bus_error = 1; wb_valid with wb_reg_write = 0; next bundle accepted on the following cycle.
- Load with no ack, TIMEOUT = 16 → mem_req drops after 16 cycles; bus_error = 1 and wb_reg_write = 0. Repeat with ack on cycle 16 → normal completion and bus_error stays 0.
- CBZ with zero = 1 and target 0x80; then zero = 0; then B → pc_src pulses with pc_target = 0x80; no pulse; pulse again.
